my_edge_detector_bank: RTL and testbench
========================================

Name: my_edge_detector_bank

Overview:
Multi-channel, parametrised edge detector and the successor to the single-channel rising-edge detector. Each channel has:
- a configurable-depth synchroniser;
- runtime mode select: off, rising, falling or both edges;
- a one-cycle pulse output and a sticky flag.

A shared saturating counter tallies all detected events. The block sits between asynchronous/external inputs (buttons, status lines) and the register/interrupt logic.

Parameters:
WIDTH, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=1)
CNT_W, 8, width of the shared event counter (>=1)
FILTER_LEN, 4, stable cycles required by the glitch filter (>=1; used only with GLITCH_FILTER_EN)

Ports:
clk  in  1  rising-edge clock; all state is clocked by it
asynch_nreset  in  1  asynchronous active-low reset
signal_input  in  WIDTH  raw channel inputs, may be asynchronous
mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
flag_clear  in  WIDTH  per-channel sticky-flag clear, level-sensitive, synchronous
count_clear  in  1  synchronous clear of event_count
pulse_output  out  WIDTH  registered one-cycle pulse per detected edge
flag_output  out  WIDTH  sticky per-channel event flags
any_pulse  out  1  registered OR of this cycle's detections
event_count  out  CNT_W  saturating total of detected events

Behaviour:
Reset:
- On asynch_nreset low, every register clears immediately, independent of clk. This covers sync chain, prev register, pulse_output, flag_output, any_pulse and event_count.
- Outputs read 0 while reset is held.
- Reset mid-operation discards in-flight edges and does not clear mode-dependent state, because there is none.

Per-channel pipeline:
- s = last synchroniser stage; p = s delayed by one clk.
- rise = s & ~p; fall = ~s & p.
- det = mode-selected combination of rise and fall: 00 gives 0.

Latency:
- Input change sampled first at edge k gives pulse_output high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1, i.e. exactly one cycle.
- With SYNC_STAGES=2, an input rising before edge 0 produces a pulse in the cycle after edge 2.

Per-edge rules:
- One edge gives one pulse. An input held steady gives no further pulses.
- Input toggles faster than one clk per level are not guaranteed to be seen.
- Mode is sampled combinationally in the detection cycle.
- s and p track the input regardless of mode, so switching from off to an active mode never creates a spurious pulse from stale history.

Reset-release behaviour:
- Sync and prev registers reset to 0.
- An input already high at reset release therefore yields a rising event after SYNC_STAGES+1 edges. This is intentional and matches the existing detector.

Sticky flags:
- flag_output[i] sets on det[i] and clears on flag_clear[i].
- Simultaneous det and clear: set wins, so no event is lost.

Counter:
- event_count_next = event_count + popcount(det), saturating at 2^CNT_W-1 with no wrap.
- count_clear with simultaneous events: result = min(popcount(det), 2^CNT_W-1).
- popcount sums WIDTH bits and is computed at sufficient width before clamping.

any_pulse:
- Registered |det, aligned with pulse_output.

Optional Feature:
GLITCH_FILTER_EN:
- Defined: adds a per-channel filter between s and edge detection.
  - Filtered value f changes to s only after s has differed from f for FILTER_LEN consecutive cycles.
  - The per-channel counter has width clog2(FILTER_LEN+1). It resets to 0 whenever s equals f.
  - Edge detection uses f and its delayed copy instead of s and p.
  - Latency grows by FILTER_LEN cycles.
  - Input pulses shorter than FILTER_LEN cycles produce no event.
  - f resets to 0.
- Undefined: no filter logic, and FILTER_LEN is ignored.

Decomposition:
Package edge_det_pkg:
- 2-bit mode typedef/constants: EDGE_OFF=00, EDGE_RISE=01, EDGE_FALL=10, EDGE_BOTH=11.
- popcount width helper constant/function.

Sub-module my_edge_channel:
- Contains sync chain, optional filter, prev register and mode-gated detect.
- Instantiated WIDTH times in a generate loop.

Top level holds pulse/flag/any_pulse registers and the shared saturating counter.

Test Plan:
1. Reset release with signal_input=0, mode=all 01; raise ch0 before edge 0 -> pulse_output=0x01 only in the cycle after edge 2; flag_output=0x01; event_count=1.
2. Ch1 mode=10, ch2 mode=11; toggle both high then low with a 5-cycle gap -> ch1 pulses once on the fall; ch2 pulses on both edges; event_count=3.
3. All 8 channels rise in the same cycle with mode=11 and CNT_W=3, then fall -> event_count saturates at 7 and never wraps; any_pulse high on both detection cycles.
4. flag_clear[0] asserted in the same cycle ch0 detects a new edge -> flag_output[0] stays 1. Same test with count_clear plus 2 simultaneous events -> event_count=2.
5. mode=00 on ch3 while it toggles, then switch to 01 with the input held high -> no pulse; the next genuine rise pulses once.
6. With GLITCH_FILTER_EN and FILTER_LEN=4: a 3-cycle high glitch gives no pulse; a 4-cycle high input gives a pulse 4 cycles later than in scenario 1. Assert asynch_nreset mid-filter -> all outputs 0 immediately.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types for the edge detector bank: per-channel mode encoding and
// the width helper used to size the event popcount.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Bits needed to hold a popcount of n one-bit inputs (0..n inclusive).
    function automatic int unsigned popcnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/my_edge_channel.sv
// One edge-detector channel: synchroniser, optional glitch filter
// (GLITCH_FILTER_EN), previous-level register and mode-gated detect.
module my_edge_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sig_i,
    input  logic [1:0] mode_i,
    output logic       det_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sig_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    // The run counter only counts consecutive disagreeing cycles; any
    // agreement, or the level flipping, restarts it from zero.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

    always_comb begin
        det_o = 1'b0;
        case (edge_mode_e'(mode_i))
            EDGE_OFF:  det_o = 1'b0;
            EDGE_RISE: det_o = rise;
            EDGE_FALL: det_o = fall;
            EDGE_BOTH: det_o = rise | fall;
            default:   det_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/my_edge_detector_bank.sv
// Multi-channel edge detector bank with registered pulses, sticky flags and a
// shared saturating event counter. Optional glitch filter: GLITCH_FILTER_EN.
module my_edge_detector_bank
    import edge_det_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic               clk,
    input  logic               asynch_nreset,
    input  logic [WIDTH-1:0]   signal_input,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   flag_clear,
    input  logic               count_clear,
    output logic [WIDTH-1:0]   pulse_output,
    output logic [WIDTH-1:0]   flag_output,
    output logic               any_pulse,
    output logic [CNT_W-1:0]   event_count
);

    localparam int unsigned PC_W  = popcnt_width(WIDTH);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] pulse_q, flag_q, flag_d;
    logic             any_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] base, sum;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        my_edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (asynch_nreset),
            .sig_i  (signal_input[g]),
            .mode_i (mode[2*g+1:2*g]),
            .det_o  (det[g])
        );
    end

    // Set dominates clear so a detection coinciding with a clear is kept.
    assign flag_d = (flag_q & ~flag_clear) | det;

    // Sum at one bit wider than either operand, then clamp.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + PC_W'(det[i]);
        end
        base  = count_clear ? '0 : SUM_W'(cnt_q);
        sum   = base + SUM_W'(pop);
        cnt_d = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum);
    end

    always_ff @(posedge clk or negedge asynch_nreset) begin
        if (!asynch_nreset) begin
            pulse_q <= '0;
            flag_q  <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= det;
            flag_q  <= flag_d;
            any_q   <= |det;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_output = pulse_q;
    assign flag_output  = flag_q;
    assign any_pulse    = any_q;
    assign event_count  = cnt_q;

endmodule

// File: tb/tb_my_edge_detector_bank.sv
// Scoreboard bench for my_edge_detector_bank: randomized channel activity
// against a history-based reference model (honours GLITCH_FILTER_EN).
module tb_my_edge_detector_bank;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int CW = 4;
    localparam int FL = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [W-1:0]     sig;
    logic [2*W-1:0]   mode;
    logic [W-1:0]     fclr;
    logic             cclr;
    logic [W-1:0]     pulse_output;
    logic [W-1:0]     flag_output;
    logic             any_pulse;
    logic [CW-1:0]    event_count;

    always #5 clk = ~clk;

    my_edge_detector_bank #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .CNT_W       (CW),
        .FILTER_LEN  (FL)
    ) dut (
        .clk           (clk),
        .asynch_nreset (rstn),
        .signal_input  (sig),
        .mode          (mode),
        .flag_clear    (fclr),
        .count_clear   (cclr),
        .pulse_output  (pulse_output),
        .flag_output   (flag_output),
        .any_pulse     (any_pulse),
        .event_count   (event_count)
    );

    typedef struct {
        logic [W-1:0] pulse;
        logic [W-1:0] flag;
        logic         any;
        int           cnt;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  samp[$];   // input sampled at each clock edge since reset release
    logic [W-1:0]  lvl[$];    // level seen by the detector after each edge
    logic [W-1:0]  flag_m;
    int            cnt_m;
    int            hold[W];
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] samp_at(input int idx);
        if (idx < 0 || idx >= samp.size()) return '0;
        return samp[idx];
    endfunction

    function automatic logic [W-1:0] lvl_at(input int idx);
        if (idx < 0 || idx >= lvl.size()) return '0;
        return lvl[idx];
    endfunction

    task automatic model_reset();
        samp.delete();
        lvl.delete();
        sb.delete();
        flag_m = '0;
        cnt_m  = 0;
    endtask

    // Expected outputs just after the coming edge, from the sampled history.
    task automatic model_edge();
        logic [W-1:0] cur, old, d, newl, prevl, sv;
        logic [1:0]   md;
        int           n, pop;
        samp.push_back(sig);
        n = samp.size() - 1;
`ifdef GLITCH_FILTER_EN
        // Level flips only after FL consecutive synchronised samples disagree.
        prevl = lvl_at(n - 1);
        newl  = prevl;
        for (int ch = 0; ch < W; ch++) begin
            bit all_diff = 1'b1;
            for (int k = 1; k <= FL; k++) begin
                sv = samp_at(n - k - SS + 1);
                if (sv[ch] == prevl[ch]) all_diff = 1'b0;
            end
            if (all_diff) newl[ch] = ~prevl[ch];
        end
`else
        prevl = '0;
        sv    = '0;
        newl  = samp_at(n - SS + 1);
`endif
        lvl.push_back(newl);
        cur = lvl_at(n - 1);
        old = lvl_at(n - 2);
        d   = '0;
        pop = 0;
        for (int ch = 0; ch < W; ch++) begin
            md = mode[2*ch +: 2];
            d[ch] = (md[0] & cur[ch] & ~old[ch]) | (md[1] & ~cur[ch] & old[ch]);
            if (d[ch]) pop++;
        end
        flag_m = (flag_m & ~fclr) | d;
        cnt_m  = (cclr ? 0 : cnt_m) + pop;
        if (cnt_m > CMAX) cnt_m = CMAX;
        sb.push_back('{pulse: d, flag: flag_m, any: |d, cnt: cnt_m});
    endtask

    task automatic drive_cycle(input bit sat, input int c);
        if (sat) begin
            if (c % 6 == 0) sig = ~sig;
            mode = '1;
            fclr = '0;
            cclr = 1'b0;
        end else begin
            for (int ch = 0; ch < W; ch++) begin
                if (hold[ch] == 0) begin
                    sig[ch]  = ~sig[ch];
                    hold[ch] = $urandom_range(1, 7);
                end else begin
                    hold[ch]--;
                end
            end
            if ($urandom_range(0, 15) == 0) mode = 16'($urandom);
            fclr = 8'($urandom & $urandom & $urandom);
            cclr = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic run(input int n, input bit sat);
        fork
            begin
                for (int c = 0; c < n; c++) begin
                    @(negedge clk);
                    drive_cycle(sat, c);
                    model_edge();
                end
            end
            begin
                exp_t e;
                for (int c = 0; c < n; c++) begin
                    @(posedge clk);
                    #1;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_output", int'(pulse_output), int'(e.pulse));
                        check("flag_output",  int'(flag_output),  int'(e.flag));
                        check("any_pulse",    int'(any_pulse),    int'(e.any));
                        check("event_count",  int'(event_count),  e.cnt);
                    end
                end
            end
        join
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"}, int'(pulse_output), 0);
        check({tag, "_flag"},  int'(flag_output),  0);
        check({tag, "_any"},   int'(any_pulse),    0);
        check({tag, "_count"}, int'(event_count),  0);
    endtask

    // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn = 1'b1;
        sig  = '0;
        mode = {W{2'b01}};
        fclr = '0;
        cclr = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_zero("reset_init");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rstn = 1'b1;
        model_reset();

        run(400, 1'b0);
        run(60, 1'b1);
        mid_reset();
        run(400, 1'b0);
        run(40, 1'b1);
        mid_reset();
        run(200, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
